// File: rtl/regfile_mp_pkg.sv
// Shared defaults for the multi-port register file.
// Holds default geometry and the link register index.
package regfile_mp_pkg;

    localparam int DSIZE_DEF    = 16;
    localparam int NREG_DEF     = 16;
    localparam int NRD_DEF      = 2;
    localparam int LINK_REG_DEF = 15;

    // Bit offset of field 'idx' in a flat vector of 'w'-bit fields
    function automatic int slice_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Pending-load scoreboard: tracks registers awaiting load writeback.
// Ports: clk, rst (async low), sb_set/sb_addr (load issue),
//   wen1/waddr1 (load return), pending, sb_err, sb_count.
module regfile_mp_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int LINK_REG = LINK_REG_DEF,
    parameter int RSIZE    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sb_set,
    input  logic [RSIZE-1:0] sb_addr,
    input  logic             wen1,
    input  logic [RSIZE-1:0] waddr1,
    output logic [NREG-1:0]  pending,
    output logic             sb_err,
    output logic [RSIZE:0]   sb_count
);

    logic [NREG-1:0] pend_nxt;
    logic            err_nxt;
    logic [RSIZE:0]  cnt_nxt;
    logic            set_ok;

    assign set_ok = sb_set
                  && (sb_addr != '0)
                  && (sb_addr != RSIZE'(LINK_REG));

    always_comb begin
        pend_nxt = pending;
        err_nxt  = 1'b0;
        if (wen1)
            pend_nxt[waddr1] = 1'b0;
        // Set after clear: a load issued in the cycle the previous
        // one returns is a fresh, legal load, so no error then.
        if (set_ok) begin
            if (pending[sb_addr] && !(wen1 && waddr1 == sb_addr))
                err_nxt = 1'b1;
            pend_nxt[sb_addr] = 1'b1;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++)
            cnt_nxt = cnt_nxt + {{RSIZE{1'b0}}, pend_nxt[i]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending  <= '0;
            sb_err   <= 1'b0;
            sb_count <= '0;
        end else begin
            pending  <= pend_nxt;
            sb_err   <= err_nxt;
            sb_count <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with link register and load scoreboard.
// Ports: clk, rst (async low); write ports wen0/1, waddr0/1, wdata0/1;
//   raddr/rdata/rbusy (NRD packed read ports); link_en/link_data/link_out;
//   sb_set/sb_addr, sb_err, sb_count.
// Option: define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DSIZE    = DSIZE_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int LINK_REG = LINK_REG_DEF,
    parameter int RSIZE    = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wen0,
    input  logic [RSIZE-1:0]     waddr0,
    input  logic [DSIZE-1:0]     wdata0,
    input  logic                 wen1,
    input  logic [RSIZE-1:0]     waddr1,
    input  logic [DSIZE-1:0]     wdata1,
    input  logic [NRD*RSIZE-1:0] raddr,
    output logic [NRD*DSIZE-1:0] rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic                 link_en,
    input  logic [DSIZE-1:0]     link_data,
    output logic [DSIZE-1:0]     link_out,
    input  logic                 sb_set,
    input  logic [RSIZE-1:0]     sb_addr,
    output logic                 sb_err,
    output logic [RSIZE:0]       sb_count
);

    localparam logic [RSIZE-1:0] LREG = RSIZE'(LINK_REG);

    logic [DSIZE-1:0] mem [NREG];
    logic [NREG-1:0]  pending;

    regfile_mp_scoreboard #(
        .NREG     (NREG),
        .LINK_REG (LINK_REG),
        .RSIZE    (RSIZE)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .wen1     (wen1),
        .waddr1   (waddr1),
        .pending  (pending),
        .sb_err   (sb_err),
        .sb_count (sb_count)
    );

    // R0 is never written; LINK_REG only through the link port.
    // Load data (wen1) beats ALU data (wen0) on the same address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++)
                mem[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (i == LINK_REG) begin
                    if (link_en)
                        mem[i] <= link_data;
                end else if (wen1 && waddr1 == RSIZE'(i)) begin
                    mem[i] <= wdata1;
                end else if (wen0 && waddr0 == RSIZE'(i)) begin
                    mem[i] <= wdata0;
                end
            end
        end
    end

    assign link_out = mem[LINK_REG];

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [RSIZE-1:0] ra;
        logic [DSIZE-1:0] d;
        logic             busy;

        assign ra = raddr[slice_lsb(p, RSIZE) +: RSIZE];

        always_comb begin
            d    = (ra == '0) ? '0 : mem[ra];
            busy = pending[ra];
`ifdef REGFILE_BYPASS_EN
            if (ra != '0) begin
                if (ra == LREG) begin
                    if (link_en)
                        d = link_data;
                end else if (wen1 && waddr1 == ra) begin
                    d = wdata1;
                end else if (wen0 && waddr0 == ra) begin
                    d = wdata0;
                end
            end
            if (wen1 && waddr1 == ra)
                busy = 1'b0;
`endif
        end

        assign rdata[slice_lsb(p, DSIZE) +: DSIZE] = d;
        assign rbusy[p] = busy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp.
// Default 16x16 two-port build plus a 32x32 four-port build.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 16-bit, 16-register, 2 read ports
    logic        wen0, wen1, link_en, sb_set;
    logic [3:0]  waddr0, waddr1, sb_addr;
    logic [15:0] wdata0, wdata1, link_data, link_out;
    logic [7:0]  raddr;
    logic [31:0] rdata;
    logic [1:0]  rbusy;
    logic        sb_err;
    logic [4:0]  sb_count;

    regfile_mp u16 (
        .clk(clk), .rst(rst),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .link_en(link_en), .link_data(link_data), .link_out(link_out),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .sb_err(sb_err), .sb_count(sb_count)
    );

    // 32-bit, 32-register, 4 read ports
    logic         w0b;
    logic [4:0]   wa0b;
    logic [31:0]  wd0b;
    logic [19:0]  rab;
    logic [127:0] rdb;
    logic [3:0]   rbb;
    logic [31:0]  lob;
    logic         seb;
    logic [5:0]   scb;

    regfile_mp #(.DSIZE(32), .NREG(32), .NRD(4), .LINK_REG(15)) u32 (
        .clk(clk), .rst(rst),
        .wen0(w0b), .waddr0(wa0b), .wdata0(wd0b),
        .wen1(1'b0), .waddr1(5'd0), .wdata1(32'd0),
        .raddr(rab), .rdata(rdb), .rbusy(rbb),
        .link_en(1'b0), .link_data(32'd0), .link_out(lob),
        .sb_set(1'b0), .sb_addr(5'd0),
        .sb_err(seb), .sb_count(scb)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen0 = 0; wen1 = 0; link_en = 0; sb_set = 0; w0b = 0;
    endtask

    initial begin
        idle();
        waddr0 = 0; waddr1 = 0; sb_addr = 0; wa0b = 0;
        wdata0 = 0; wdata1 = 0; link_data = 0; wd0b = 0;
        raddr = 8'h03; rab = '0;
        #12;
        chk("rst_rdata", {16'h0, rdata[15:0]}, 32'h0);
        chk("rst_count", {27'h0, sb_count}, 32'h0);
        chk("rst_link", {16'h0, link_out}, 32'h0);
        rst = 1;
        tick();

        // Reset mid-run
        wen0 = 1; waddr0 = 3; wdata0 = 16'h1234;
        sb_set = 1; sb_addr = 4;
        tick(); idle();
        chk("pre_rst_r3", {16'h0, rdata[15:0]}, 32'h1234);
        chk("pre_rst_cnt", {27'h0, sb_count}, 32'h1);
        #2 rst = 0;
        #1;
        chk("async_rst_r3", {16'h0, rdata[15:0]}, 32'h0);
        chk("async_rst_cnt", {27'h0, sb_count}, 32'h0);
        #1 rst = 1;
        tick();

        // R0 and link register protection
        wen0 = 1; waddr0 = 0; wdata0 = 16'hFFFF;
        wen1 = 1; waddr1 = 15; wdata1 = 16'hAAAA;
        link_en = 1; link_data = 16'h0042;
        tick(); idle();
        raddr = {4'd15, 4'd0};
        #1;
        chk("r0_zero", {16'h0, rdata[15:0]}, 32'h0);
        chk("link_rd", {16'h0, rdata[31:16]}, 32'h0042);
        chk("link_out", {16'h0, link_out}, 32'h0042);
        wen0 = 1; waddr0 = 15; wdata0 = 16'hBEEF;
        tick(); idle();
        chk("link_wen0_ign", {16'h0, link_out}, 32'h0042);

        // Write collision
        wen0 = 1; waddr0 = 5; wdata0 = 16'h5555;
        tick(); idle();
        raddr = {4'd0, 4'd5};
        wen0 = 1; waddr0 = 5; wdata0 = 16'h1111;
        wen1 = 1; waddr1 = 5; wdata1 = 16'h2222;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("coll_same", {16'h0, rdata[15:0]}, 32'h2222);
`else
        chk("coll_same", {16'h0, rdata[15:0]}, 32'h5555);
`endif
        tick(); idle();
        chk("coll_next", {16'h0, rdata[15:0]}, 32'h2222);

        // Scoreboard set / clear
        sb_set = 1; sb_addr = 7;
        tick(); idle();
        raddr = {4'd0, 4'd7};
        #1;
        chk("sb_busy", {31'h0, rbusy[0]}, 32'h1);
        chk("sb_cnt1", {27'h0, sb_count}, 32'h1);
        wen1 = 1; waddr1 = 7; wdata1 = 16'h0BAD;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("ld_busy_same", {31'h0, rbusy[0]}, 32'h0);
        chk("ld_data_same", {16'h0, rdata[15:0]}, 32'h0BAD);
`else
        chk("ld_busy_same", {31'h0, rbusy[0]}, 32'h1);
        chk("ld_data_same", {16'h0, rdata[15:0]}, 32'h0);
`endif
        tick(); idle();
        chk("ld_busy_next", {31'h0, rbusy[0]}, 32'h0);
        chk("ld_cnt0", {27'h0, sb_count}, 32'h0);
        chk("ld_data_next", {16'h0, rdata[15:0]}, 32'h0BAD);

        // Double set -> error pulse
        sb_set = 1; sb_addr = 7;
        tick();
        chk("err_first", {31'h0, sb_err}, 32'h0);
        tick(); idle();
        chk("err_pulse", {31'h0, sb_err}, 32'h1);
        chk("err_cnt", {27'h0, sb_count}, 32'h1);
        tick();
        chk("err_clear", {31'h0, sb_err}, 32'h0);

        // Set and load return on same register
        sb_set = 1; sb_addr = 7;
        wen1 = 1; waddr1 = 7; wdata1 = 16'h0777;
        tick(); idle();
        chk("race_busy", {31'h0, rbusy[0]}, 32'h1);
        chk("race_cnt", {27'h0, sb_count}, 32'h1);
        chk("race_data", {16'h0, rdata[15:0]}, 32'h0777);

        // wen0 to pending register keeps it pending
        wen0 = 1; waddr0 = 7; wdata0 = 16'h3333;
        tick(); idle();
        chk("wen0_pend", {31'h0, rbusy[0]}, 32'h1);
        chk("wen0_data", {16'h0, rdata[15:0]}, 32'h3333);

        // Ignored sets and non-pending load return
        sb_set = 1; sb_addr = 0;
        tick();
        sb_addr = 15;
        tick(); idle();
        wen1 = 1; waddr1 = 9; wdata1 = 16'h0909;
        tick(); idle();
        chk("ign_cnt", {27'h0, sb_count}, 32'h1);
        chk("ign_err", {31'h0, sb_err}, 32'h0);
        raddr = {4'd9, 4'd0};
        #1;
        chk("r0_busy", {31'h0, rbusy[0]}, 32'h0);
        chk("r9_data", {16'h0, rdata[31:16]}, 32'h0909);

        // Count accumulates
        sb_set = 1; sb_addr = 2;
        tick();
        sb_addr = 3;
        tick(); idle();
        chk("cnt3", {27'h0, sb_count}, 32'h3);

        // Four-port wide instance
        w0b = 1; wa0b = 1;  wd0b = 32'h1111_0001;
        tick();
        wa0b = 8;  wd0b = 32'h2222_0008;
        tick();
        wa0b = 16; wd0b = 32'h3333_0010;
        tick();
        wa0b = 31; wd0b = 32'h4444_001F;
        tick(); idle();
        rab = {5'd31, 5'd16, 5'd8, 5'd1};
        #1;
        chk("w_p0", rdb[31:0],   32'h1111_0001);
        chk("w_p1", rdb[63:32],  32'h2222_0008);
        chk("w_p2", rdb[95:64],  32'h3333_0010);
        chk("w_p3", rdb[127:96], 32'h4444_001F);
        chk("w_busy", {28'h0, rbb}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
